// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store stage: FSM states, access sizes,
// AXI response codes and the byte-strobe helper.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_REQ,
      WR_RESP
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic [1:0] OKAY   = 2'd0;
   localparam logic [1:0] SLVERR = 2'd2;
   localparam logic [1:0] DECERR = 2'd3;

   // Unshifted strobe for an access of 2^size bytes.
   function automatic logic [7:0] strb_base(input logic [1:0] size);
      return 8'((16'd1 << (4'd1 << size)) - 16'd1);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment: load-side shift plus sign/zero extension, store-side data shift
// and byte-strobe generation. Purely combinational.
module lsu_align
   import lsu_pkg::*;
#(
   parameter int  XLEN   = 32,
   localparam int STRB_W = XLEN / 8,
   localparam int OFF_W  = $clog2(STRB_W)
) (
   input  logic [OFF_W-1:0]  off,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [XLEN-1:0]   rdata,
   input  logic [XLEN-1:0]   st_src,
   output logic [XLEN-1:0]   ld_data,
   output logic [XLEN-1:0]   wdata,
   output logic [STRB_W-1:0] wstrb
);

   logic [XLEN-1:0] lane;
   logic [XLEN-1:0] keep;
   logic            sign;

   always_comb begin
      lane = rdata >> {off, 3'b000};
      keep = '1;
      sign = lane[XLEN-1];
      case (size)
         SZ_B: begin keep = XLEN'(8'hFF);         sign = lane[7];  end
         SZ_H: begin keep = XLEN'(16'hFFFF);      sign = lane[15]; end
         SZ_W: begin keep = XLEN'(32'hFFFF_FFFF); sign = lane[31]; end
         default: ;
      endcase
      ld_data = (lane & keep) | ((sign && !uns) ? ~keep : '0);
   end

   assign wdata = st_src << {off, 3'b000};
   assign wstrb = STRB_W'(strb_base(size)) << off;

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage: one AXI4-Lite transaction per load/store, pass-through
// otherwise. Define LSU_MISALIGN_TRAP_EN to fault on misaligned accesses instead of aligning.
module lsu_stage
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int SIDE_W = 96
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_last,
   output logic                ready_last,
   input  logic                mem_ren,
   input  logic                mem_wen,
   input  logic [2:0]          funct3,
   input  logic [XLEN-1:0]     ex_result,
   input  logic [XLEN-1:0]     rs2_value,
   input  logic [SIDE_W-1:0]   side_in,
   output logic                valid_next,
   input  logic                ready_next,
   output logic [XLEN-1:0]     mem_rdata,
   output logic [XLEN-1:0]     ex_result_next,
   output logic [SIDE_W-1:0]   side_next,
   output logic                mem_ren_next,
   output logic                fault,
   output logic                fault_store,
   output logic                fault_misalign,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [XLEN-1:0]     rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [XLEN-1:0]     wdata,
   output logic [XLEN/8-1:0]   wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam int STRB_W = XLEN / 8;
   localparam int OFF_W  = $clog2(STRB_W);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [1:0]      size;
      logic            uns;
   } req_t;

   state_t            state, state_nx;
   req_t              req;
   logic              aw_done, w_done;
   logic              accept, mem_op, illegal, misalign, go_bus;
   logic [XLEN-1:0]   low_mask, addr_in, ld_data, st_data;
   logic [STRB_W-1:0] st_strb;

   assign ready_last = (state == IDLE) && (!valid_next || ready_next);
   assign accept     = valid_last && ready_last;
   assign mem_op     = mem_ren || mem_wen;
   assign low_mask   = (XLEN'(1) << funct3[1:0]) - XLEN'(1);
   assign illegal    = mem_op && ((funct3 == 3'b111) || (XLEN == 32 && funct3[1:0] == SZ_D));

`ifdef LSU_MISALIGN_TRAP_EN
   // Naturally aligned accesses never straddle an XLEN word, so alignment is the only check.
   assign misalign = mem_op && !illegal && ((ex_result & low_mask) != '0);
   assign addr_in  = ex_result;

   always_ff @(posedge clk) begin
      if (rst)         fault_misalign <= 1'b0;
      else if (accept) fault_misalign <= misalign;
   end
`else
   assign misalign       = 1'b0;
   assign addr_in        = ex_result & ~low_mask;
   assign fault_misalign = 1'b0;
`endif

   assign go_bus = mem_op && !illegal && !misalign;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept && go_bus) state_nx = mem_wen ? WR_REQ : RD_ADDR;
         RD_ADDR: if (arready) state_nx = RD_DATA;
         RD_DATA: if (rvalid) state_nx = IDLE;
         WR_REQ:  if ((aw_done || awready) && (w_done || wready)) state_nx = WR_RESP;
         WR_RESP: if (bvalid) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The done flags let AW and W retire independently while the other is still waiting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         state   <= state_nx;
         aw_done <= (state == WR_REQ) && (state_nx == WR_REQ) && (aw_done || awready);
         w_done  <= (state == WR_REQ) && (state_nx == WR_REQ) && (w_done || wready);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req            <= '0;
         valid_next     <= 1'b0;
         mem_rdata      <= '0;
         ex_result_next <= '0;
         side_next      <= '0;
         mem_ren_next   <= 1'b0;
         fault          <= 1'b0;
         fault_store    <= 1'b0;
      end else begin
         if (valid_next && ready_next) valid_next <= 1'b0;
         if (accept) begin
            req            <= '{addr: addr_in, data: rs2_value, size: funct3[1:0], uns: funct3[2]};
            valid_next     <= !go_bus;
            mem_rdata      <= '0;
            ex_result_next <= ex_result;
            side_next      <= side_in;
            mem_ren_next   <= mem_ren;
            fault          <= illegal || misalign;
            fault_store    <= (illegal || misalign) && mem_wen;
         end
         if (state == RD_DATA && rvalid) begin
            valid_next <= 1'b1;
            mem_rdata  <= (rresp == OKAY) ? ld_data : '0;
            fault      <= (rresp != OKAY);
         end
         if (state == WR_RESP && bvalid) begin
            valid_next  <= 1'b1;
            fault       <= (bresp != OKAY);
            fault_store <= (bresp != OKAY);
         end
      end
   end

   lsu_align #(.XLEN(XLEN)) u_align (
      .off     (req.addr[OFF_W-1:0]),
      .size    (req.size),
      .uns     (req.uns),
      .rdata   (rdata),
      .st_src  (req.data),
      .ld_data (ld_data),
      .wdata   (st_data),
      .wstrb   (st_strb)
   );

   assign arvalid = (state == RD_ADDR);
   assign rready  = (state == RD_DATA);
   assign awvalid = (state == WR_REQ) && !aw_done;
   assign wvalid  = (state == WR_REQ) && !w_done;
   assign bready  = (state == WR_RESP);
   assign araddr  = ADDR_W'(req.addr);
   assign awaddr  = ADDR_W'(req.addr);
   assign wdata   = st_data;
   assign wstrb   = (state == WR_REQ) ? st_strb : '0;

endmodule
